// File: rtl/acc_cpu_pkg.sv
// Shared encodings for the accumulator core: FSM states, opcodes and flag bit positions.
package acc_cpu_pkg;

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef logic [2:0] flags_t;

  // Immediate-operand ALU ops take op2 from the instruction instead of DR.
  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the accumulator result and updated Z/C/N flags.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  flags_t        flags_in,
  output logic [DW-1:0] result,
  output flags_t        flags_out
);

  logic [DW:0] sum;
  logic [DW:0] diff;
  logic        zn_update;

  always_comb begin
    sum       = {1'b0, op1} + {1'b0, op2};
    diff      = {1'b0, op1} - {1'b0, op2};
    result    = op1;
    flags_out = flags_in;
    zn_update = 1'b0;
    case (opcode)
      OP_LDI, OP_LD: begin
        result    = op2;
        zn_update = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        result            = sum[DW-1:0];
        flags_out[FLAG_C] = sum[DW];
        zn_update         = 1'b1;
      end
      // The extra MSB of the widened difference is the borrow (op1 < op2).
      OP_SUB, OP_SUBI: begin
        result            = diff[DW-1:0];
        flags_out[FLAG_C] = diff[DW];
        zn_update         = 1'b1;
      end
      OP_AND: begin
        result    = op1 & op2;
        zn_update = 1'b1;
      end
      OP_OR: begin
        result    = op1 | op2;
        zn_update = 1'b1;
      end
      OP_XOR: begin
        result    = op1 ^ op2;
        zn_update = 1'b1;
      end
      default: ;
    endcase
    if (zn_update) begin
      flags_out[FLAG_Z] = (result == '0);
      flags_out[FLAG_N] = result[DW-1];
    end
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator processor: streamed program load, FETCH/DECODE/EXECUTE loop,
// conditional branches, HALT and a back-pressured output port.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter  int DW       = 8,
  parameter  int PM_DEPTH = 16,
  parameter  int DM_DEPTH = 16,
  localparam int IW       = DW + 4,
  localparam int PAW      = $clog2(PM_DEPTH),
  localparam int DAW      = $clog2(DM_DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ld_valid,
  input  logic [IW-1:0]  ld_data,
  input  logic           ld_last,
  output logic           ld_ready,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  input  logic           out_ready,
  output logic           halted,
  output logic [2:0]     cur_state,
  output logic [PAW-1:0] pc,
  output logic [DW-1:0]  acc
);

  logic [IW-1:0]  pm [PM_DEPTH];
  logic [DW-1:0]  dm [DM_DEPTH];

  logic [2:0]     state_reg;
  logic [PAW-1:0] load_addr_reg;
  logic [PAW-1:0] pc_reg;
  logic [DW-1:0]  acc_reg;
  logic [DW-1:0]  dr_reg;
  logic [IW-1:0]  ir_reg;
  flags_t         flags_reg;
  logic           out_valid_reg;

  logic [3:0]     opcode;
  logic [DW-1:0]  imm;
  logic [DW-1:0]  alu_op2;
  logic [DW-1:0]  alu_result;
  flags_t         alu_flags;
  logic           jump_taken;

  assign opcode  = ir_reg[IW-1:DW];
  assign imm     = ir_reg[DW-1:0];
  assign alu_op2 = uses_imm(opcode) ? imm : dr_reg;

  acc_cpu_alu #(.DW(DW)) u_alu (
    .opcode    (opcode),
    .op1       (acc_reg),
    .op2       (alu_op2),
    .flags_in  (flags_reg),
    .result    (alu_result),
    .flags_out (alu_flags)
  );

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flags_reg[FLAG_Z];
      OP_JC:   jump_taken = flags_reg[FLAG_C];
      default: ;
    endcase
  end

  // Memory writes carry no reset so PM/DM contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && state_reg == ST_LOAD && ld_valid)
      pm[load_addr_reg] <= ld_data;
  end

  always_ff @(posedge CLK) begin
    if (!RST && state_reg == ST_EXECUTE && opcode == OP_ST)
      dm[imm[DAW-1:0]] <= acc_reg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_LOAD;
      load_addr_reg <= '0;
      pc_reg        <= '0;
      acc_reg       <= '0;
      dr_reg        <= '0;
      ir_reg        <= '0;
      flags_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (ld_valid) begin
            if (ld_last || load_addr_reg == PAW'(PM_DEPTH - 1)) begin
              state_reg     <= ST_FETCH;
              load_addr_reg <= '0;
              pc_reg        <= '0;
              acc_reg       <= '0;
              dr_reg        <= '0;
              ir_reg        <= '0;
              flags_reg     <= '0;
            end else begin
              load_addr_reg <= load_addr_reg + 1'b1;
            end
          end
        end
        ST_FETCH: begin
          ir_reg    <= pm[pc_reg];
          state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          dr_reg        <= dm[imm[DAW-1:0]];
          out_valid_reg <= (opcode == OP_OUT);
          state_reg     <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (opcode == OP_OUT) begin
            // Everything holds until the sink takes the word.
            if (out_valid_reg && out_ready) begin
              out_valid_reg <= 1'b0;
              pc_reg        <= pc_reg + 1'b1;
              state_reg     <= ST_FETCH;
            end
          end else if (opcode == OP_HLT) begin
            state_reg <= ST_HALT;
          end else begin
            acc_reg   <= alu_result;
            flags_reg <= alu_flags;
            pc_reg    <= jump_taken ? imm[PAW-1:0] : pc_reg + 1'b1;
            state_reg <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  assign ld_ready  = (state_reg == ST_LOAD);
  assign halted    = (state_reg == ST_HALT);
  assign out_valid = out_valid_reg;
  assign out_data  = acc_reg;
  assign cur_state = state_reg;
  assign pc        = pc_reg;
  assign acc       = acc_reg;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: programs are streamed in, OUT words are scored
// against an expected-value queue, and state/pc/acc are checked at key points.
module tb_acc_cpu_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ld_valid = 1'b0;
  logic [11:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        ld_ready, out_valid, halted;
  logic [7:0]  out_data, acc;
  logic [2:0]  cur_state;
  logic [3:0]  pc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  sb[$];
  logic [7:0]  sb_exp;
  logic [11:0] prog[16];

  always #5 CLK = ~CLK;

  acc_cpu_core dut (
    .CLK       (CLK),
    .RST       (RST),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .cur_state (cur_state),
    .pc        (pc),
    .acc       (acc)
  );

  // A handshake seen at the falling edge completes at the next rising edge.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL out_unexpected: observed %02h required none", out_data);
      end else begin
        sb_exp = sb.pop_front();
        $display("out transfer: data %02h expected %02h", out_data, sb_exp);
        assert (out_data === sb_exp) else begin
          miscompares++;
          $error("FAIL out_data: observed %02h required %02h", out_data, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic load(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = use_last && (i == n - 1);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("load_done_state", cur_state, 1);
  endtask

  task automatic wait_halt(input string tag, input int pc_req);
    int n = 0;
    while (!halted && n < 300) begin
      step();
      n++;
    end
    check({tag, "_halted"}, halted, 1);
    check({tag, "_pc"}, pc, pc_req);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
  endtask

  initial begin
    int cyc;

    // Reset state
    step();
    step();
    RST = 1'b0;
    check("rst_state", cur_state, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);

    // Load + add: LDI 5; ADDI 3; OUT; HLT
    prog[0] = 12'h105; prog[1] = 12'h503; prog[2] = 12'hE00; prog[3] = 12'hF00;
    sb.push_back(8'h08);
    out_ready = 1'b1;
    load(4, 1'b1);
    check("run_ld_ready", ld_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("out_latency", cyc, 9);
    wait_halt("t1", 3);
    check("t1_acc", acc, 8'h08);
    step(); step(); step();
    check("t1_pc_frozen", pc, 3);
    check("t1_state_halt", cur_state, 4);

    // Carry / borrow and conditional branches
    do_reset();
    prog[0]  = 12'h1F0; prog[1]  = 12'h520; prog[2]  = 12'hE00; prog[3]  = 12'hC0C;
    prog[4]  = 12'h711; prog[5]  = 12'hE00; prog[6]  = 12'hD09; prog[7]  = 12'h133;
    prog[8]  = 12'hE00; prog[9]  = 12'h501; prog[10] = 12'hE00; prog[11] = 12'hF00;
    prog[12] = 12'h1EE; prog[13] = 12'hE00; prog[14] = 12'hF00;
    sb.push_back(8'h10); sb.push_back(8'hFF); sb.push_back(8'h00);
    load(15, 1'b1);
    wait_halt("t2", 11);
    check("t2_acc", acc, 8'h00);

    // Memory round trip, Z/C branches, logic ops and OUT back-pressure
    do_reset();
    out_ready = 1'b0;
    prog[0]  = 12'h107; prog[1]  = 12'h302; prog[2]  = 12'h100; prog[3]  = 12'h202;
    prog[4]  = 12'hE00; prog[5]  = 12'h707; prog[6]  = 12'hD09; prog[7]  = 12'hC0A;
    prog[8]  = 12'h1BB; prog[9]  = 12'hE00; prog[10] = 12'hE00; prog[11] = 12'h10C;
    prog[12] = 12'h902; prog[13] = 12'hA02; prog[14] = 12'hE00; prog[15] = 12'hF00;
    sb.push_back(8'h07); sb.push_back(8'h00); sb.push_back(8'h08);
    load(16, 1'b0);
    wait_out_valid("bp");
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_state", cur_state, 3);
      check("bp_hold_pc", pc, 4);
      check("bp_hold_acc", acc, 8'h07);
      check("bp_hold_data", out_data, 8'h07);
      step();
    end
    out_ready = 1'b1;
    check("bp_valid_cycle5", out_valid, 1);
    step();
    check("bp_valid_drop", out_valid, 0);
    check("bp_next_state", cur_state, 1);
    check("bp_next_pc", pc, 5);
    wait_halt("t3", 15);
    check("t3_acc", acc, 8'h08);

    // Full 16-word load without ld_last; PC wraps; ld_valid ignored while running
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 12'h000;
    load(16, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 12'hF00;
    for (int i = 0; i < 17; i++) begin
      check("wrap_state", cur_state, 1);
      check("wrap_pc", pc, i % 16);
      step(); step(); step();
    end
    check("wrap_ld_ready", ld_ready, 0);
    ld_valid = 1'b0;

    // Reset during an OUT stall
    do_reset();
    out_ready = 1'b0;
    prog[0] = 12'h15A; prog[1] = 12'hE00; prog[2] = 12'hF00;
    load(3, 1'b1);
    wait_out_valid("stall");
    check("stall_data", out_data, 8'h5A);
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_stall_state", cur_state, 0);
    check("rst_stall_out_valid", out_valid, 0);
    check("rst_stall_ld_ready", ld_ready, 1);
    check("rst_stall_pc", pc, 0);
    check("rst_stall_acc", acc, 0);

    // Reset on load beat 3, then reload from address 0
    ld_valid = 1'b1;
    ld_data  = 12'hF00;
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    ld_valid = 1'b0;
    check("rst_load_state", cur_state, 0);
    check("rst_load_ld_ready", ld_ready, 1);
    prog[0] = 12'h13C; prog[1] = 12'hE00; prog[2] = 12'hF00;
    sb.push_back(8'h3C);
    out_ready = 1'b1;
    load(3, 1'b1);
    wait_halt("t5", 2);
    check("t5_acc", acc, 8'h3C);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
